// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: takes the round-10 key and emits round keys 10 down to 0,
// one per valid/ready handshake, with a registered SubWord stage between steps.
module inv_key_expansion #(
  parameter int unsigned KEY_SIZE  = 128,
  parameter int unsigned ROUNDS    = 10,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KEY_SIZE-1:0]       last_key,
  output logic [KEY_SIZE-1:0]       key_out,
  output logic [$clog2(ROUNDS):0]   key_round,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned RW = $clog2(ROUNDS) + 1;

  typedef enum logic [2:0] {StIdle, StEmit, StCalcA, StCalcB, StDone} state_e;

  state_e               state;
  logic [KEY_SIZE-1:0]  key_r;
  logic [RW-1:0]        round_r;
  logic [WORD_SIZE-1:0] sub_r;

  logic [WORD_SIZE-1:0] w0, w1, w2, w3, t3, rot_t3, sub_next, rcon_word;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine(x^254) in GF(2^8); x^254 is the multiplicative inverse (0 maps to 0).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] inv;
    p   = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_SIZE-1:0] sub_word(input logic [WORD_SIZE-1:0] w);
    logic [WORD_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WORD_SIZE / 8); i++) begin
      r[8*i +: 8] = sbox(w[8*i +: 8]);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] r);
    logic [7:0] c;
    case (r)
      RW'(1):  c = 8'h01;
      RW'(2):  c = 8'h02;
      RW'(3):  c = 8'h04;
      RW'(4):  c = 8'h08;
      RW'(5):  c = 8'h10;
      RW'(6):  c = 8'h20;
      RW'(7):  c = 8'h40;
      RW'(8):  c = 8'h80;
      RW'(9):  c = 8'h1b;
      RW'(10): c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    w0        = key_r[KEY_SIZE-1 -: WORD_SIZE];
    w1        = key_r[KEY_SIZE-WORD_SIZE-1 -: WORD_SIZE];
    w2        = key_r[KEY_SIZE-2*WORD_SIZE-1 -: WORD_SIZE];
    w3        = key_r[KEY_SIZE-3*WORD_SIZE-1 -: WORD_SIZE];
    t3        = w2 ^ w3;
    rot_t3    = {t3[WORD_SIZE-9:0], t3[WORD_SIZE-1 -: 8]};
    sub_next  = sub_word(rot_t3);
    rcon_word = {rcon(round_r), {(WORD_SIZE-8){1'b0}}};
  end

  assign key_out   = key_r;
  assign key_round = round_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      key_r     <= '0;
      round_r   <= '0;
      sub_r     <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            key_r     <= last_key;
            round_r   <= RW'(ROUNDS);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= StEmit;
          end
        end
        StEmit: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            if (round_r == '0) begin
              done  <= 1'b1;
              state <= StDone;
            end else begin
              state <= StCalcA;
            end
          end
        end
        StCalcA: begin
          sub_r <= sub_next;
          state <= StCalcB;
        end
        StCalcB: begin
          key_r     <= {w0 ^ sub_r ^ rcon_word, w0 ^ w1, w1 ^ w2, w2 ^ w3};
          round_r   <= round_r - RW'(1);
          key_valid <= 1'b1;
          state     <= StEmit;
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion: expected keys come from a table-driven forward
// AES-128 expansion and are popped as the DUT hands keys over.
module tb_inv_key_expansion;

  logic         clk, rst_n, start, key_ready, key_valid, busy, done;
  logic [127:0] last_key, key_out;
  logic [4:0]   key_round;

  inv_key_expansion dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key), .key_out(key_out),
    .key_round(key_round), .key_valid(key_valid), .key_ready(key_ready), .busy(busy),
    .done(done)
  );

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0] sbox [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rcon_tab [1:10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  typedef struct packed {
    logic [4:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         sb[$];
  int           hs_edges[$];
  int           done_cycles[$];
  logic [127:0] model_keys [0:10];
  logic [127:0] seen_keys [0:31];
  int           errors = 0, checks = 0, cyc = 0, hs_count = 0, s_edge = 0;
  bit           rand_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 key_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected summary");
    $fatal(1, "watchdog");
  end

  // Monitor: each handshake pops one expected key from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && key_valid && key_ready) begin
      hs_edges.push_back(cyc + 1);
      hs_count++;
      seen_keys[key_round] = key_out;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got round %0d key %h, expected no key", key_round, key_out);
      end else begin
        e = sb.pop_front();
        if (key_round !== e.rnd || key_out !== e.key) begin
          errors++;
          $display("FAIL sb_key: got round %0d key %h, expected round %0d key %h",
                   key_round, key_out, e.rnd, e.key);
        end
      end
    end
    if (done) done_cycles.push_back(cyc);
  end

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Walk back to the round-0 key, then forward-expand it to produce all 11 expected keys.
  task automatic compute_model(input logic [127:0] last);
    logic [127:0] k;
    logic [31:0]  a, b, c, d, tmp;
    logic [31:0]  w [0:43];
    k = last;
    for (int r = 10; r >= 1; r--) begin
      {a, b, c, d} = k;
      tmp = c ^ d;
      k = {a ^ sw({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[r], 24'h0}, a ^ b, b ^ c, tmp};
    end
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sw({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/4], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start_run(input logic [127:0] key);
    exp_t e;
    compute_model(key);
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 5'(r);
      e.key = model_keys[r];
      sb.push_back(e);
    end
    hs_edges.delete();
    done_cycles.delete();
    hs_count = 0;
    @(posedge clk);
    #1 start = 1'b1;
    last_key = key;
    @(posedge clk);
    #1 s_edge = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done pulse, expected done within 400 cycles", name);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left: got %0d keys outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic wait_key(input logic [4:0] r);
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (key_valid && key_round == r) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_round: got no valid key, expected round %0d within 200 cycles", r);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; last_key = '0;
    #12;
    checks += 5;
    if (key_out !== '0)   begin errors++; $display("FAIL reset_key_out: got %h, expected 0", key_out); end
    if (key_round !== '0) begin errors++; $display("FAIL reset_round: got %0d, expected 0", key_round); end
    if (key_valid !== 0)  begin errors++; $display("FAIL reset_valid: got %b, expected 0", key_valid); end
    if (busy !== 0)       begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 0)       begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips;
    key_ready = 1'b1;
    start_run(FIPS_K10);
    checks += 3;
    if (key_valid !== 1)       begin errors++; $display("FAIL fips_first_valid: got %b, expected 1", key_valid); end
    if (key_round !== 5'd10)   begin errors++; $display("FAIL fips_first_round: got %0d, expected 10", key_round); end
    if (key_out !== FIPS_K10)  begin errors++; $display("FAIL fips_k10: got %h, expected %h", key_out, FIPS_K10); end
    wait_done("fips");
    checks += 4;
    if (hs_count != 11)         begin errors++; $display("FAIL fips_handshakes: got %0d, expected 11", hs_count); end
    if (seen_keys[9] !== FIPS_K9) begin errors++; $display("FAIL fips_k9: got %h, expected %h", seen_keys[9], FIPS_K9); end
    if (seen_keys[1] !== FIPS_K1) begin errors++; $display("FAIL fips_k1: got %h, expected %h", seen_keys[1], FIPS_K1); end
    if (seen_keys[0] !== FIPS_K0) begin errors++; $display("FAIL fips_k0: got %h, expected %h", seen_keys[0], FIPS_K0); end
  endtask

  task automatic test_timing;
    key_ready = 1'b1;
    start_run(FIPS_K10);
    wait_done("timing");
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL timing_busy_after: got %b, expected 0", busy); end
    @(negedge clk);
    checks += 2;
    if (hs_edges.size() != 11) begin
      errors++; $display("FAIL timing_hs_count: got %0d, expected 11", hs_edges.size());
    end else begin
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (hs_edges[k] != s_edge + 1 + 3 * k) begin
          errors++;
          $display("FAIL timing_hs_edge: got S+%0d, expected S+%0d", hs_edges[k] - s_edge, 1 + 3 * k);
        end
      end
    end
    if (done_cycles.size() != 1 || done_cycles[0] != s_edge + 31) begin
      errors++;
      $display("FAIL timing_done: got %0d done cycles (first S+%0d), expected 1 at S+31",
               done_cycles.size(), done_cycles.size() > 0 ? done_cycles[0] - s_edge : -1);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] hold;
    key_ready = 1'b1;
    start_run(FIPS_K10);
    wait_key(5'd8);
    @(posedge clk);
    #1 key_ready = 1'b0;
    wait_key(5'd7);
    hold = key_out;
    repeat (5) begin
      @(negedge clk);
      checks += 3;
      if (key_valid !== 1)   begin errors++; $display("FAIL bp_valid: got %b, expected 1", key_valid); end
      if (key_round !== 5'd7) begin errors++; $display("FAIL bp_round: got %0d, expected 7", key_round); end
      if (key_out !== hold)  begin errors++; $display("FAIL bp_key: got %h, expected %h", key_out, hold); end
    end
    @(posedge clk);
    #1 key_ready = 1'b1;
    wait_done("bp");
  endtask

  task automatic test_start_busy;
    key_ready = 1'b1;
    start_run(FIPS_K10);
    wait_key(5'd6);
    @(posedge clk);
    #1 start = 1'b1;
    last_key = 128'h0123456789abcdeffedcba9876543210;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy_start");
    checks++;
    if (hs_count != 11) begin errors++; $display("FAIL busy_start_hs: got %0d, expected 11", hs_count); end
  endtask

  task automatic test_reset_mid;
    key_ready = 1'b1;
    start_run(FIPS_K10);
    wait_key(5'd5);
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (key_valid !== 0)  begin errors++; $display("FAIL rmid_valid: got %b, expected 0", key_valid); end
    if (busy !== 0)       begin errors++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
    if (done !== 0)       begin errors++; $display("FAIL rmid_done: got %b, expected 0", done); end
    if (key_out !== '0)   begin errors++; $display("FAIL rmid_key: got %h, expected 0", key_out); end
    if (key_round !== '0) begin errors++; $display("FAIL rmid_round: got %0d, expected 0", key_round); end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(FIPS_K10);
    wait_done("rmid_rerun");
    checks++;
    if (hs_count != 11) begin errors++; $display("FAIL rmid_rerun_hs: got %0d, expected 11", hs_count); end
  endtask

  task automatic test_random;
    rand_mode = 1;
    for (int i = 0; i < 100; i++) begin
      start_run({$urandom, $urandom, $urandom, $urandom});
      wait_done("random");
    end
    rand_mode = 0;
    @(posedge clk);
    #2 key_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_fips;
    test_timing;
    test_backpressure;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
